// File: rtl/mra_pkg.sv
// Shared types and default widths for the MRA responder.
package mra_pkg;

    localparam int unsigned MRA_ADDR_WIDTH = 64;
    localparam int unsigned MRA_DATA_WIDTH = 64;
    localparam int unsigned MRA_FIFO_DEPTH = 8;
    localparam int unsigned MRA_PERF_WIDTH = 32;

    typedef enum logic {
        MRA_READ  = 1'b0,
        MRA_WRITE = 1'b1
    } mra_rw_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } mra_rsp_state_e;

endpackage

// File: rtl/mra_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count, empty and full.
// Head data reads as zero while empty so the output is defined after reset.
module mra_rsp_fifo
    import mra_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MRA_DATA_WIDTH,
    parameter int unsigned DEPTH      = MRA_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [CNT_WIDTH-1:0]  o_count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_WIDTH'(DEPTH));
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mra_responder.sv
// Far end of the MRA request interface: forwards requests to a memory port,
// buffers read data in a FWFT FIFO and withholds MRA_ready unless every
// outstanding read has a guaranteed FIFO slot.
// Optional performance counters: define MRA_RESPONDER_PERF_EN.
module mra_responder
    import mra_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MRA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MRA_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = MRA_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] MRA_req_addr,
    input  logic                  MRA_rw,
    input  logic                  MRA_req_valid,
    output logic                  MRA_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_we,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  FIFO_rd_en,
    output logic [DATA_WIDTH-1:0] FIFO_rd_data,
    output logic                  FIFO_empty,
    output logic                  rsp_error,
    output logic [MRA_PERF_WIDTH-1:0] perf_rd_cnt,
    output logic [MRA_PERF_WIDTH-1:0] perf_wr_cnt,
    output logic [MRA_PERF_WIDTH-1:0] perf_stall_cnt
);

    mra_rsp_state_e        r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic                  r_valid;
    logic                  r_rsp_error;
    logic [CNT_WIDTH-1:0]  r_pending_rd;
    logic [CNT_WIDTH-1:0]  w_fifo_count;
    logic [CNT_WIDTH:0]    w_reserved;
    logic                  w_fifo_full;
    logic                  w_credit_ok;
    logic                  w_accept;
    logic                  w_accept_rd;
    logic                  w_rsp_ok;

    // Slots already promised: reads in flight plus entries waiting to be drained.
    assign w_reserved  = (CNT_WIDTH+1)'(r_pending_rd) + (CNT_WIDTH+1)'(w_fifo_count);
    assign w_credit_ok = (w_reserved < (CNT_WIDTH+1)'(FIFO_DEPTH));

    assign MRA_ready   = !rst && ((r_state == IDLE) || mem_req_ready)
                         && ((MRA_rw == MRA_WRITE) || w_credit_ok);
    assign w_accept    = MRA_req_valid && MRA_ready;
    assign w_accept_rd = w_accept && (MRA_rw == MRA_READ);
    // A response is only stored if a read is owed; anything else is dropped.
    assign w_rsp_ok    = mem_rsp_valid && (r_pending_rd != '0) && !w_fifo_full;

    assign mem_req_addr  = r_addr;
    assign mem_req_we    = r_we;
    assign mem_req_valid = r_valid;
    assign rsp_error     = r_rsp_error;

    // Request FSM: capture on accept, hold the memory request until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= MRA_req_addr;
                        r_we    <= MRA_rw;
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        if (w_accept) begin
                            r_addr <= MRA_req_addr;
                            r_we   <= MRA_rw;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Reads owed by memory: up on read accept, down on each stored response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending_rd <= '0;
        end else begin
            case ({w_accept_rd, w_rsp_ok})
                2'b10:   r_pending_rd <= r_pending_rd + CNT_WIDTH'(1);
                2'b01:   r_pending_rd <= r_pending_rd - CNT_WIDTH'(1);
                default: r_pending_rd <= r_pending_rd;
            endcase
        end
    end

    // Sticky protocol error: unsolicited response or pop while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_error <= 1'b0;
        end else if ((mem_rsp_valid && !w_rsp_ok) || (FIFO_rd_en && FIFO_empty)) begin
            r_rsp_error <= 1'b1;
        end
    end

    // Credit must make it impossible for an owed response to find the FIFO full.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && (r_pending_rd != '0) && w_fifo_full));

    mra_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_ok),
        .i_data  (mem_rsp_data),
        .i_pop   (FIFO_rd_en),
        .o_data  (FIFO_rd_data),
        .o_empty (FIFO_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

`ifdef MRA_RESPONDER_PERF_EN
    logic [MRA_PERF_WIDTH-1:0] r_perf_rd;
    logic [MRA_PERF_WIDTH-1:0] r_perf_wr;
    logic [MRA_PERF_WIDTH-1:0] r_perf_stall;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_rd    <= '0;
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept_rd) begin
                r_perf_rd <= r_perf_rd + MRA_PERF_WIDTH'(1);
            end
            if (w_accept && (MRA_rw == MRA_WRITE)) begin
                r_perf_wr <= r_perf_wr + MRA_PERF_WIDTH'(1);
            end
            if (MRA_req_valid && !MRA_ready) begin
                r_perf_stall <= r_perf_stall + MRA_PERF_WIDTH'(1);
            end
        end
    end

    assign perf_rd_cnt    = r_perf_rd;
    assign perf_wr_cnt    = r_perf_wr;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_rd_cnt    = '0;
    assign perf_wr_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mra_responder.sv
// Directed bench for mra_responder with a one-cycle-latency memory model and
// a scoreboard of expected read data, filled as reads are accepted.
module tb_mra_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] MRA_req_addr;
    logic        MRA_rw;
    logic        MRA_req_valid;
    logic        MRA_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        FIFO_rd_en;
    logic [63:0] FIFO_rd_data;
    logic        FIFO_empty;
    logic        rsp_error;
    logic [31:0] perf_rd_cnt;
    logic [31:0] perf_wr_cnt;
    logic [31:0] perf_stall_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mra_responder dut (
        .clk            (clk),
        .rst            (rst),
        .MRA_req_addr   (MRA_req_addr),
        .MRA_rw         (MRA_rw),
        .MRA_req_valid  (MRA_req_valid),
        .MRA_ready      (MRA_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .FIFO_rd_en     (FIFO_rd_en),
        .FIFO_rd_data   (FIFO_rd_data),
        .FIFO_empty     (FIFO_empty),
        .rsp_error      (rsp_error),
        .perf_rd_cnt    (perf_rd_cnt),
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    // Memory contents as seen by the bench: 0x1000 holds 0xDEAD, others hold their address.
    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return (a == 64'h1000) ? 64'hDEAD : a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Called on a negedge; advances one clock and returns on the next negedge.
    task automatic tick();
        logic        hs;
        logic        acc;
        logic [63:0] a;
        #2;
        hs  = mem_req_valid && mem_req_ready && !mem_req_we;
        a   = mem_req_addr;
        acc = MRA_req_valid && MRA_ready;
        if (acc && (MRA_rw == 1'b0)) exp_q.push_back(mem_val(MRA_req_addr));
        @(posedge clk);
        #1;
        mem_rsp_valid = hs;
        mem_rsp_data  = hs ? mem_val(a) : 64'd0;
        if (acc) MRA_req_valid = 1'b0;
        FIFO_rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_req(input logic [63:0] a, input logic rw);
        MRA_req_addr  = a;
        MRA_rw        = rw;
        MRA_req_valid = 1'b1;
        #1;
    endtask

    // Compare the FIFO head with the scoreboard and request a pop at the next edge.
    task automatic expect_pop(input string tag);
        chk({tag, "_nonempty"}, 64'(FIFO_empty), 64'd0);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed scoreboard empty expected an entry", tag);
        end else begin
            chk(tag, FIFO_rd_data, exp_q.pop_front());
        end
        FIFO_rd_en = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        expect_pop(tag);
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},  64'(MRA_ready),     64'd0);
        chk({tag, "_mvalid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_maddr"},  mem_req_addr,       64'd0);
        chk({tag, "_mwe"},    64'(mem_req_we),    64'd0);
        chk({tag, "_empty"},  64'(FIFO_empty),    64'd1);
        chk({tag, "_rdata"},  FIFO_rd_data,       64'd0);
        chk({tag, "_err"},    64'(rsp_error),     64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        MRA_req_addr  = 64'd0;
        MRA_rw        = 1'b0;
        MRA_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'd0;
        FIFO_rd_en    = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        chk("rst0_perf_rd",    64'(perf_rd_cnt),    64'd0);
        chk("rst0_perf_wr",    64'(perf_wr_cnt),    64'd0);
        chk("rst0_perf_stall", 64'(perf_stall_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read at 0x1000
        mem_req_ready = 1'b1;
        set_req(64'h1000, 1'b0);
        chk("t1_ready", 64'(MRA_ready), 64'd1);
        tick();
        chk("t1_mvalid", 64'(mem_req_valid), 64'd1);
        chk("t1_maddr",  mem_req_addr,       64'h1000);
        chk("t1_mwe",    64'(mem_req_we),    64'd0);
        tick();
        chk("t1_mvalid_drop", 64'(mem_req_valid), 64'd0);
        chk("t1_empty_rsp",   64'(FIFO_empty),    64'd1);
        tick();
        pop_check("t1_data");
        chk("t1_empty_after", 64'(FIFO_empty), 64'd1);

        // Eight reads fill the credit; the ninth waits for a pop
        for (int i = 0; i < 8; i++) begin
            set_req(64'h100 + 64'(i), 1'b0);
            chk("t2_ready_fill", 64'(MRA_ready), 64'd1);
            tick();
        end
        set_req(64'h108, 1'b0);
        chk("t2_ready_full", 64'(MRA_ready), 64'd0);
        repeat (3) tick();
        chk("t2_ready_still_full", 64'(MRA_ready), 64'd0);
        pop_check("t2_head");
        #1;
        chk("t2_ready_after_pop", 64'(MRA_ready), 64'd1);
        tick();
        repeat (2) tick();

        // Writes need no credit while all eight slots are reserved
        set_req(64'h2000, 1'b1);
        chk("t3_wr_ready", 64'(MRA_ready), 64'd1);
        tick();
        chk("t3_wr_mvalid", 64'(mem_req_valid), 64'd1);
        chk("t3_wr_mwe",    64'(mem_req_we),    64'd1);
        chk("t3_wr_maddr",  mem_req_addr,       64'h2000);
        set_req(64'h2008, 1'b1);
        chk("t3_wr2_ready", 64'(MRA_ready), 64'd1);
        tick();
        chk("t3_wr2_maddr", mem_req_addr, 64'h2008);
        set_req(64'h2010, 1'b0);
        chk("t3_rd_blocked", 64'(MRA_ready), 64'd0);
        MRA_req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) pop_check("t3_drain");
        chk("t3_empty", 64'(FIFO_empty), 64'd1);

        // Memory back-pressure for five cycles, then back-to-back accept
        mem_req_ready = 1'b0;
        set_req(64'h3000, 1'b0);
        chk("t4_ready_idle", 64'(MRA_ready), 64'd1);
        tick();
        set_req(64'h3010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_mvalid", 64'(mem_req_valid), 64'd1);
            chk("t4_hold_maddr",  mem_req_addr,       64'h3000);
            chk("t4_hold_mwe",    64'(mem_req_we),    64'd0);
            chk("t4_hold_ready",  64'(MRA_ready),     64'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        chk("t4_release_ready", 64'(MRA_ready), 64'd1);
        tick();
        chk("t4_b2b_mvalid", 64'(mem_req_valid), 64'd1);
        chk("t4_b2b_maddr",  mem_req_addr,       64'h3010);
        chk("t4_b2b_mwe",    64'(mem_req_we),    64'd1);
        tick();
        pop_check("t4_data");
        chk("t4_empty", 64'(FIFO_empty), 64'd1);

        // Twenty reads with steady push+pop at occupancy 3, wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            set_req(64'(i), 1'b0);
            chk("t5_ready", 64'(MRA_ready), 64'd1);
            if (i >= 5) expect_pop("t5_data");
            tick();
        end
        repeat (2) tick();
        for (int i = 0; i < 5; i++) pop_check("t5_tail");
        chk("t5_empty", 64'(FIFO_empty), 64'd1);
        chk("t5_err",   64'(rsp_error),  64'd0);

        // Reset while a request is stalled in ISSUE with two entries queued
        set_req(64'h4000, 1'b0);
        tick();
        set_req(64'h4008, 1'b0);
        tick();
        repeat (2) tick();
        mem_req_ready = 1'b0;
        set_req(64'h4010, 1'b0);
        tick();
        tick();
        chk("t6_pre_mvalid", 64'(mem_req_valid), 64'd1);
        chk("t6_pre_empty",  64'(FIFO_empty),    64'd0);
        rst = 1'b1;
        #1;
        chk_reset("t6_rst");
        exp_q.delete();
        MRA_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unsolicited response after reset
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD;
        tick();
        chk("t6_spur_err",   64'(rsp_error),  64'd1);
        chk("t6_spur_empty", 64'(FIFO_empty), 64'd1);

        // Pop on empty after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_err_clear", 64'(rsp_error), 64'd0);
        FIFO_rd_en = 1'b1;
        tick();
        chk("t7_pop_err",   64'(rsp_error),  64'd1);
        chk("t7_pop_empty", 64'(FIFO_empty), 64'd1);
        chk("t7_pop_rdata", FIFO_rd_data,    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mra_responder.md
Name: mra_responder

Overview:
- Far end of the MRA request interface: accepts address/rw requests from the tensor-core dispatch controller and forwards them to a memory port.
- Buffers returned read data in a response FIFO that the consumer drains with FIFO_rd_en.
- Credit-based flow control: MRA_ready is withheld unless FIFO space is guaranteed for every outstanding read.

Parameters:
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 64, read data width
- FIFO_DEPTH, 8, response FIFO entries; power of two, >=2
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of occupancy/credit counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- MRA_req_addr  in  ADDR_WIDTH  request address
- MRA_rw  in  1  0=read, 1=write
- MRA_req_valid  in  1  request valid
- MRA_ready  out  1  request accepted when valid&&ready
- mem_req_addr  out  ADDR_WIDTH  memory request address
- mem_req_we  out  1  memory write enable (copy of MRA_rw)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  read data returning, in order, one per read
- mem_rsp_data  in  DATA_WIDTH  read data
- FIFO_rd_en  in  1  pop response head
- FIFO_rd_data  out  DATA_WIDTH  head entry, first-word-fall-through
- FIFO_empty  out  1  no response available
- rsp_error  out  1  sticky: response with no pending read, or pop on empty

Behaviour:
- Reset (async, rst=1): state IDLE; MRA_ready=0; mem_req_valid=0; mem_req_addr=0; mem_req_we=0; FIFO_empty=1; FIFO_rd_data=0; rsp_error=0; all counters 0. Any mid-operation transfer is abandoned. The memory side is reset on the same rst.
- FSM IDLE/ISSUE:
  - IDLE: mem_req_valid=0. An accepted request is captured into the request register and the FSM moves to ISSUE.
  - ISSUE: mem_req_valid=1, address and we held stable until mem_req_ready.
  - On mem_req_ready: a new request accepted in the same cycle stays in ISSUE (back-to-back); otherwise the FSM returns to IDLE.
- Credit accounting:
  - pending_rd: increments on acceptance of a read; decrements on mem_rsp_valid.
  - reserved = pending_rd + fifo_count.
  - MRA_ready = (state==IDLE || mem_req_ready) && (MRA_rw==1 || reserved < FIFO_DEPTH). MRA_ready has a combinational dependency on mem_req_ready and MRA_rw only.
  - Writes consume no credit and produce no response.
- Latency: request accepted at cycle N gives mem_req_valid at N+1 at the earliest. mem_rsp_valid at cycle M makes FIFO_empty=0 at M+1.
- FIFO:
  - Circular pointers wrap at FIFO_DEPTH; fifo_count is 0..FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged. When the FIFO is empty, a push followed by a pop in the next cycle is legal.
  - Pop when empty: ignored, rsp_error set.
  - mem_rsp_valid with pending_rd==0: data dropped, rsp_error set. Overflow is impossible by credit, and an assertion checks this.
- All counters saturate-free by construction. Width is sufficient for FIFO_DEPTH.

Optional Feature:
- MRA_RESPONDER_PERF_EN adds output ports perf_rd_cnt[31:0], perf_wr_cnt[31:0] and perf_stall_cnt[31:0].
- perf_rd_cnt and perf_wr_cnt count accepted reads and writes.
- perf_stall_cnt counts cycles with MRA_req_valid=1 and MRA_ready=0.
- All three wrap at 2^32 and reset to 0.
- Without the macro the ports remain and are tied to 0, and no counter logic is generated.

Decomposition:
- Package mra_pkg:
  - typedef mra_rw_e {MRA_READ=1'b0, MRA_WRITE=1'b1}
  - typedef mra_rsp_state_e {IDLE, ISSUE}
  - default width constants
- Natural sub-module: mra_rsp_fifo (parameterised FWFT FIFO with count, empty and full). The FSM and credit logic stay in the top.

Test Plan:
- Single read at 0x1000, mem_req_ready=1, response 0xDEAD one cycle later -> mem_req_addr=0x1000 and we=0; FIFO_empty falls; FIFO_rd_data=0xDEAD; pop -> empty.
- 8 reads with no pops, FIFO_DEPTH=8, memory responding -> 9th read sees MRA_ready=0 until one pop, then accepted the following cycle.
- Writes interleaved with full credit (reserved=8) -> writes accepted; no FIFO entries created.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid, addr and we stable; MRA_ready=0; on release, back-to-back request accepted in the same cycle.
- Simultaneous push and pop with count=3 -> count stays 3; data order preserved across pointer wrap (20 reads, values 0..19 read back in order).
- rst asserted while in ISSUE with 2 entries queued -> outputs return to reset values asynchronously. Spurious mem_rsp_valid after reset -> rsp_error=1, FIFO_empty stays 1.
